// File: rtl/serial_tx_pkg.sv
// Shared definitions for the serial bit transmitter: FSM state encodings and
// the saturation limit helper used by the consecutive-ones counter.
package serial_tx_pkg;

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_SHIFT = 2'd1;
   localparam logic [1:0] ST_DONE  = 2'd2;

   // All-ones value of a w-bit counter, limited to a 32-bit result.
   function automatic logic [31:0] sat_max(input int unsigned w);
      if (w >= 32) return '1;
      return (32'd1 << w) - 32'd1;
   endfunction

endpackage

// File: rtl/serial_bit_tx_ones3_window_cnt.sv
// Saturating count of overlapping "111" windows in a bit stream; the two-bit
// history is cleared at frame start so windows never span frames.
module ones3_window_cnt
   import serial_tx_pkg::*;
#(
   parameter int CNT_W = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             clr,
   input  logic             bit_in,
   input  logic             bit_en,
   output logic [CNT_W-1:0] cnt
);

   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(sat_max(CNT_W));

   logic [1:0]       hist_q, hist_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;

   always_comb begin
      hist_d = hist_q;
      cnt_d  = cnt_q;
      if (clr) begin
         hist_d = 2'b00;
      end else if (bit_en) begin
         hist_d = {hist_q[0], bit_in};
         if (bit_in && (hist_q == 2'b11) && (cnt_q != CNT_MAX))
            cnt_d = cnt_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         hist_q <= 2'b00;
         cnt_q  <= '0;
      end else begin
         hist_q <= hist_d;
         cnt_q  <= cnt_d;
      end
   end

   assign cnt = cnt_q;

endmodule

// File: rtl/serial_bit_tx.sv
// Parallel-to-serial transmitter: loads a frame via valid/ready, shifts it out
// MSB-first, and keeps a golden count of transmitted "111" windows.
//
// state    | meaning
// ST_IDLE  | waiting for a frame offer; load_ready asserted
// ST_SHIFT | sending one bit per unpaused cycle until rem reaches zero
// ST_DONE  | frame finished; done pulse is registered out of this state
module serial_bit_tx
   import serial_tx_pkg::*;
#(
   parameter int WIDTH = 16,
   parameter int LEN_W = 5,
   parameter int CNT_W = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             load_valid,
   output logic             load_ready,
   input  logic [WIDTH-1:0] load_data,
   input  logic [LEN_W-1:0] load_len,
   input  logic             pause,
   output logic             a,
   output logic             a_valid,
   output logic             busy,
   output logic             done,
   output logic [CNT_W-1:0] ones3_cnt
);

   logic [1:0]       state_q, state_d;
   logic [WIDTH-1:0] shreg_q, shreg_d;
   logic [LEN_W-1:0] rem_q, rem_d;
   logic             a_q, a_d;
   logic             a_valid_q, a_valid_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;
   logic             load_ready_q, load_ready_d;

   logic             fire;
   logic             shift_en;
   logic [LEN_W-1:0] len_clamped;

   always_comb begin
      state_d      = state_q;
      shreg_d      = shreg_q;
      rem_d        = rem_q;
      a_d          = a_q;
      fire         = load_valid && load_ready_q && (state_q == ST_IDLE);
      shift_en     = (state_q == ST_SHIFT) && !pause;
      len_clamped  = (load_len > LEN_W'(WIDTH)) ? LEN_W'(WIDTH) : load_len;

      case (state_q)
         ST_IDLE: begin
            if (fire) begin
               shreg_d = load_data;
               rem_d   = len_clamped;
               state_d = (len_clamped != '0) ? ST_SHIFT : ST_DONE;
            end
         end
         ST_SHIFT: begin
            if (!pause) begin
               a_d     = shreg_q[WIDTH-1];
               shreg_d = shreg_q << 1;
               rem_d   = rem_q - LEN_W'(1);
               if (rem_q == LEN_W'(1)) state_d = ST_DONE;
            end
         end
         ST_DONE: state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase

      // Flags lag the state by one edge so done appears the cycle after the
      // last bit; ready must still drop on the handshake edge itself.
      a_valid_d    = shift_en;
      done_d       = (state_q == ST_DONE);
      load_ready_d = (state_q == ST_IDLE) && !fire;
      busy_d       = !load_ready_d;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= ST_IDLE;
         shreg_q      <= '0;
         rem_q        <= '0;
         a_q          <= 1'b0;
         a_valid_q    <= 1'b0;
         busy_q       <= 1'b0;
         done_q       <= 1'b0;
         load_ready_q <= 1'b1;
      end else begin
         state_q      <= state_d;
         shreg_q      <= shreg_d;
         rem_q        <= rem_d;
         a_q          <= a_d;
         a_valid_q    <= a_valid_d;
         busy_q       <= busy_d;
         done_q       <= done_d;
         load_ready_q <= load_ready_d;
      end
   end

   ones3_window_cnt #(.CNT_W(CNT_W)) u_ones3 (
      .clk    (clk),
      .rst    (rst),
      .clr    (fire),
      .bit_in (shreg_q[WIDTH-1]),
      .bit_en (shift_en),
      .cnt    (ones3_cnt)
   );

   assign a          = a_q;
   assign a_valid    = a_valid_q;
   assign busy       = busy_q;
   assign done       = done_q;
   assign load_ready = load_ready_q;

endmodule

// File: tb/tb_serial_bit_tx.sv
// Directed bench for serial_bit_tx: stimulus pushes expected bits and counts
// into queues; a negedge monitor pops and compares on a_valid and done.
module tb_serial_bit_tx;

   logic        clk = 1'b0;
   logic        rst;
   logic        load_valid;
   logic [15:0] load_data;
   logic [4:0]  load_len;
   logic        pause;
   logic        load_ready, a, a_valid, busy, done;
   logic [7:0]  ones3_cnt;
   logic        s_load_ready, s_a, s_a_valid, s_busy, s_done;
   logic [1:0]  s_ones3_cnt;

   int n_cmp = 0;
   int n_bad = 0;
   bit exp_bits[$];
   int exp_cnt[$];

   always #5 clk = ~clk;

   serial_bit_tx dut (
      .clk(clk), .rst(rst), .load_valid(load_valid), .load_ready(load_ready),
      .load_data(load_data), .load_len(load_len), .pause(pause), .a(a),
      .a_valid(a_valid), .busy(busy), .done(done), .ones3_cnt(ones3_cnt)
   );

   serial_bit_tx #(.WIDTH(16), .LEN_W(5), .CNT_W(2)) dut_sat (
      .clk(clk), .rst(rst), .load_valid(load_valid), .load_ready(s_load_ready),
      .load_data(load_data), .load_len(load_len), .pause(pause), .a(s_a),
      .a_valid(s_a_valid), .busy(s_busy), .done(s_done), .ones3_cnt(s_ones3_cnt)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d want %0d at %0t", name, act, exp, $time);
      end
   endtask

   // Monitor: compares every presented bit and every done pulse against the queues.
   always @(negedge clk) begin
      if (a_valid === 1'b1) begin
         if (exp_bits.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL unexpected_bit: a=%0b with no bit expected at %0t", a, $time);
         end else begin
            check("bit", a, exp_bits.pop_front());
         end
      end
      if (done === 1'b1) begin
         if (exp_cnt.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL unexpected_done: done=1 with no frame end expected at %0t", $time);
         end else begin
            int e;
            e = exp_cnt.pop_front();
            check("ones3_cnt_at_done", ones3_cnt, e);
            check("ones3_cnt_sat_at_done", s_ones3_cnt, (e > 3) ? 3 : e);
            check("a_valid_at_done", a_valid, 0);
         end
      end
   end

   task automatic push_bits(input logic [15:0] d, input int n);
      for (int i = 0; i < n; i++) exp_bits.push_back(d[15-i]);
   endtask

   // Offer a frame; returns at the negedge just after the handshake edge.
   task automatic handshake(input logic [15:0] d, input logic [4:0] l);
      @(negedge clk);
      check("ready_at_offer", load_ready, 1);
      load_valid = 1'b1;
      load_data  = d;
      load_len   = l;
      @(posedge clk);
      @(negedge clk);
      load_valid = 1'b0;
      load_data  = 16'h0000;
      load_len   = 5'd0;
   endtask

   task automatic check_reset_vals(input string tag);
      check({tag, "_a"}, a, 0);
      check({tag, "_a_valid"}, a_valid, 0);
      check({tag, "_busy"}, busy, 0);
      check({tag, "_done"}, done, 0);
      check({tag, "_load_ready"}, load_ready, 1);
      check({tag, "_ones3_cnt"}, ones3_cnt, 0);
      check({tag, "_ones3_cnt_sat"}, s_ones3_cnt, 0);
   endtask

   initial begin
      #20000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1; load_valid = 1'b0; load_data = '0; load_len = '0; pause = 1'b0;
      repeat (3) @(negedge clk);
      check_reset_vals("reset");
      rst = 1'b0;

      // 1: 1001111 -> two overlapping windows; done at N+8, ready at N+9
      push_bits(16'h9E00, 7);
      exp_cnt.push_back(2);
      handshake(16'h9E00, 5'd7);
      check("t1_ready_low", load_ready, 0);
      check("t1_busy_high", busy, 1);
      check("t1_no_bit_yet", a_valid, 0);
      repeat (7) @(negedge clk);
      check("t1_last_bit_valid", a_valid, 1);
      check("t1_done_not_yet", done, 0);
      @(negedge clk);
      check("t1_done", done, 1);
      check("t1_busy_in_done", busy, 1);
      check("t1_ready_in_done", load_ready, 0);
      check("t1_a_held", a, 1);
      @(negedge clk);
      check("t1_done_one_cycle", done, 0);
      check("t1_ready_back", load_ready, 1);
      check("t1_busy_low", busy, 0);

      // 2: 111 then 1 -- no window across frames
      push_bits(16'hE000, 3);
      exp_cnt.push_back(3);
      handshake(16'hE000, 5'd3);
      repeat (5) @(negedge clk);
      check("t2_ready_back", load_ready, 1);
      push_bits(16'h8000, 1);
      exp_cnt.push_back(3);
      handshake(16'h8000, 5'd1);
      repeat (3) @(negedge clk);
      check("t2_cnt_after_1bit", ones3_cnt, 3);

      // 3: zero-length frame
      exp_cnt.push_back(3);
      handshake(16'hFFFF, 5'd0);
      check("t3_no_bit", a_valid, 0);
      @(negedge clk);
      check("t3_done", done, 1);
      check("t3_no_bit_done", a_valid, 0);
      @(negedge clk);
      check("t3_ready_back", load_ready, 1);
      check("t3_cnt", ones3_cnt, 3);

      // 4: length 31 clamps to 16 bits, 14 windows
      push_bits(16'hFFFF, 16);
      exp_cnt.push_back(17);
      handshake(16'hFFFF, 5'd31);
      repeat (18) @(negedge clk);
      check("t4_ready_back", load_ready, 1);
      check("t4_cnt", ones3_cnt, 17);

      // 5: pause for 3 cycles after the 2nd bit
      push_bits(16'hF000, 4);
      exp_cnt.push_back(19);
      handshake(16'hF000, 5'd4);
      repeat (2) @(negedge clk);
      pause = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check("t5_gap_valid", a_valid, 0);
         check("t5_gap_a_held", a, 1);
         check("t5_gap_cnt", ones3_cnt, 17);
      end
      pause = 1'b0;
      repeat (4) @(negedge clk);
      check("t5_ready_back", load_ready, 1);
      check("t5_cnt", ones3_cnt, 19);

      // 6: reset after 3rd bit abandons the frame
      push_bits(16'hFFC0, 3);
      handshake(16'hFFC0, 5'd10);
      repeat (3) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      check_reset_vals("t6_midframe_rst");
      rst = 1'b0;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         check("t6_no_done", done, 0);
         check("t6_idle_ready", load_ready, 1);
      end

      // 6b: saturation of the 2-bit counter
      push_bits(16'hFFFF, 16);
      exp_cnt.push_back(14);
      handshake(16'hFFFF, 5'd16);
      repeat (18) @(negedge clk);
      check("t6_ready_back", load_ready, 1);
      check("t6_cnt", ones3_cnt, 14);
      check("t6_cnt_sat", s_ones3_cnt, 3);

      check("bits_all_seen", exp_bits.size(), 0);
      check("dones_all_seen", exp_cnt.size(), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
